popcount_unary_tx: RTL and testbench

Serial unary transmitter: the inverse of the popcount reducer. Accepts a count k (0..N) on a valid/ready input and emits an N-bit frame one bit per beat over a valid/ready output. The first k bits of the frame are 1 and the remaining N−k bits are 0, giving thermometer order. The block drives test vectors and serialised activations into popcount circuits on the printed-neuron datapath, and any popcount of an emitted frame returns k.

---
 rtl/popcount_unary_pkg.sv | 10 +
 rtl/popcount_unary_tx.sv | 79 +++++++
 tb/tb_popcount_unary_tx.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/popcount_unary_pkg.sv
// popcount_unary_pkg: shared FSM state type and count-width helper for the popcount family.
package popcount_unary_pkg;

   typedef enum logic {IDLE, EMIT} state_t;

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/popcount_unary_tx.sv
// popcount_unary_tx: serial thermometer transmitter, k ones then N-k zeros per N-beat frame.
// Define POPCOUNT_UNARY_TX_OVF_EN to add a sticky ovf flag for counts above N.
module popcount_unary_tx
   import popcount_unary_pkg::*;
#(
   parameter int N = 3,
   parameter int W = cnt_w(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_count,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_bit,
`ifdef POPCOUNT_UNARY_TX_OVF_EN
   output logic         out_last,
   output logic         ovf
`else
   output logic         out_last
`endif
);

   localparam logic [W-1:0] NMAX = W'(N);
   localparam logic [W-1:0] LAST = W'(N - 1);

   state_t         state_q, state_d;
   logic [W-1:0]   k_q, k_d, idx_q, idx_d;
   logic           in_hs, out_hs;

   assign out_valid = state_q == EMIT;
   assign out_bit   = idx_q < k_q;
   assign out_last  = out_valid && idx_q == LAST;
   // Accepting on the last beat lets the next frame start with no bubble.
   assign in_ready  = !rst && (state_q == IDLE || (out_last && out_ready));
   assign in_hs     = in_valid && in_ready;
   assign out_hs    = out_valid && out_ready;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      idx_d   = idx_q;
      if (in_hs) begin
         state_d = EMIT;
         k_d     = in_count > NMAX ? NMAX : in_count;
         idx_d   = '0;
      end else if (out_hs) begin
         state_d = out_last ? IDLE : EMIT;
         idx_d   = out_last ? '0 : idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         idx_q   <= idx_d;
      end
   end

`ifdef POPCOUNT_UNARY_TX_OVF_EN
   logic ovf_q;

   always_ff @(posedge clk) begin
      if (rst)
         ovf_q <= 1'b0;
      else if (in_hs && in_count > NMAX)
         ovf_q <= 1'b1;
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_popcount_unary_tx.sv
// tb_popcount_unary_tx: directed scoreboard bench for popcount_unary_tx at N=3 and N=5.
module tb_popcount_unary_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       iv3 = 1'b0, or3 = 1'b1, ir3, ov3, ob3, ol3;
   logic [1:0] ic3 = '0;
   logic       iv5 = 1'b0, or5 = 1'b1, ir5, ov5, ob5, ol5;
   logic [2:0] ic5 = '0;
`ifdef POPCOUNT_UNARY_TX_OVF_EN
   logic       ovf3, ovf5;
`endif

   int n_chk = 0;
   int n_fail = 0;
   logic [1:0] q3[$];
   logic [1:0] q5[$];

   always #5 clk = ~clk;

   popcount_unary_tx #(.N(3), .W(2)) u3 (
      .clk(clk), .rst(rst), .in_valid(iv3), .in_ready(ir3), .in_count(ic3),
      .out_valid(ov3), .out_ready(or3), .out_bit(ob3),
`ifdef POPCOUNT_UNARY_TX_OVF_EN
      .out_last(ol3), .ovf(ovf3)
`else
      .out_last(ol3)
`endif
   );

   popcount_unary_tx #(.N(5), .W(3)) u5 (
      .clk(clk), .rst(rst), .in_valid(iv5), .in_ready(ir5), .in_count(ic5),
      .out_valid(ov5), .out_ready(or5), .out_bit(ob5),
`ifdef POPCOUNT_UNARY_TX_OVF_EN
      .out_last(ol5), .ovf(ovf5)
`else
      .out_last(ol5)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: frames are queued as {bit,last} beats when a count is accepted.
   always @(negedge clk) begin
      if (!rst) begin
         if (ov3 && or3) begin
            chk("u3_beat_expected", q3.size() != 0, 1);
            if (q3.size() != 0) chk("u3_beat", {ob3, ol3}, q3.pop_front());
         end
         if (iv3 && ir3)
            for (int i = 0; i < 3; i++)
               q3.push_back({i < ((ic3 > 3) ? 3 : int'(ic3)), i == 2});
         if (ov5 && or5) begin
            chk("u5_beat_expected", q5.size() != 0, 1);
            if (q5.size() != 0) chk("u5_beat", {ob5, ol5}, q5.pop_front());
         end
         if (iv5 && ir5)
            for (int i = 0; i < 5; i++)
               q5.push_back({i < ((ic5 > 5) ? 5 : int'(ic5)), i == 4});
      end
   end

   task automatic send3(input logic [1:0] k);
      int t = 0;
      iv3 = 1'b1;
      ic3 = k;
      @(negedge clk);
      while (!ir3 && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("send3_ready", ir3, 1);
      @(posedge clk); #1;
      iv3 = 1'b0;
   endtask

   task automatic send5(input logic [2:0] k);
      int t = 0;
      iv5 = 1'b1;
      ic5 = k;
      @(negedge clk);
      while (!ir5 && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("send5_ready", ir5, 1);
      @(posedge clk); #1;
      iv5 = 1'b0;
   endtask

   task automatic done3();
      int t = 0;
      @(negedge clk);
      while (ov3 && t < 60) begin
         @(negedge clk);
         t++;
      end
      chk("done3_idle", ov3, 0);
      chk("q3_drained", q3.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic done5();
      int t = 0;
      @(negedge clk);
      while (ov5 && t < 60) begin
         @(negedge clk);
         t++;
      end
      chk("done5_idle", ov5, 0);
      chk("q5_drained", q5.size(), 0);
      @(posedge clk); #1;
   endtask

   initial begin
      logic       pstall, pb, pl, fin;
      logic [2:0] sr;
      int         b;
      // reset state
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_ov", ov3, 0);
      chk("rst_ir", ir3, 0);
      chk("rst_ob", ob3, 0);
      chk("rst_ol", ol3, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ir", ir3, 1);
      chk("post_rst_ir5", ir5, 1);
      @(posedge clk); #1;

      // k=2: 1,1,0 starting one cycle after the handshake
      chk("lat_before", ov3, 0);
      send3(2);
      @(negedge clk);
      chk("lat_first_valid", ov3, 1);
      @(posedge clk); #1;
      done3();

      // k=0 then k=3 back-to-back with in_valid held
      iv3 = 1'b1;
      ic3 = 2'd0;
      @(negedge clk);
      chk("b2b_ready0", ir3, 1);
      @(posedge clk); #1;
      ic3 = 2'd3;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("b2b_valid", ov3, 1);
         if (i < 3) chk("b2b_ready_last", ir3, i == 2);
         @(posedge clk); #1;
         if (i == 2) iv3 = 1'b0;
      end
      done3();

      // all-ones and saturated frames
      send3(3);
      done3();
`ifdef POPCOUNT_UNARY_TX_OVF_EN
      chk("ovf3_clear", ovf3, 0);
`endif
      send5(3'd7);
      done5();
`ifdef POPCOUNT_UNARY_TX_OVF_EN
      chk("ovf5_set", ovf5, 1);
`endif
      send5(3'd2);
      done5();
`ifdef POPCOUNT_UNARY_TX_OVF_EN
      chk("ovf5_sticky", ovf5, 1);
`endif

      // random out_ready stalls on a k=1 frame
      send3(1);
      or3 = 1'b0;
      pstall = 1'b0;
      pb = 1'b0;
      pl = 1'b0;
      fin = 1'b0;
      for (int c = 0; c < 60 && !fin; c++) begin
         @(negedge clk);
         if (pstall) begin
            chk("stall_hold_bit", ob3, pb);
            chk("stall_hold_last", ol3, pl);
         end
         if (ov3) chk("stall_ir", ir3, ol3 && or3);
         pstall = ov3 && !or3;
         pb = ob3;
         pl = ol3;
         fin = ov3 && or3 && ol3;
         @(posedge clk); #1;
         or3 = 1'($urandom_range(0, 1));
      end
      chk("stall_frame_done", fin, 1);
      or3 = 1'b1;
      done3();

      // reset in the middle of a k=3 frame
      send3(3);
      @(posedge clk); #1;
      rst = 1'b1;
      q3.delete();
      q5.delete();
      @(negedge clk);
      chk("midrst_ir_now", ir3, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("midrst_ov", ov3, 0);
      chk("midrst_ir", ir3, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_ir_after", ir3, 1);
      @(posedge clk); #1;
      send3(1);
      done3();

      // loopback: serial frame into a 3-bit shift register, then popcount
      for (int k = 0; k < 4; k++) begin
         sr = '0;
         b = 0;
         send3(2'(k));
         for (int c = 0; c < 20 && b < 3; c++) begin
            @(negedge clk);
            if (ov3 && or3) begin
               sr = {sr[1:0], ob3};
               b++;
            end
            @(posedge clk); #1;
         end
         chk("loop_popcount", $countones(sr), k);
      end
      done3();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
